serializer8: RTL
================

# serializer8

Parallel-in, serial-out transmitter for 8-bit words. It accepts one byte through a load/ready handshake, then drives it out one bit per clock with a valid strobe and a bit index. It pulses `done` when the word is complete. It is the outbound counterpart of the 8-bit register and shifter datapath: the register captures a parallel byte, and this block reads that byte and streams it to a serial consumer.

## Interface
Parameters:
- `MSB_FIRST`, default 1: 1 = transmit bit 7 first; 0 = transmit bit 0 first.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `d`  in  8  parallel word to transmit; sampled only on an accepted load.
- `load`  in  1  request to accept `d`; accepted when `load & ready` at a rising edge.
- `ready`  out  1  high in IDLE only; block can accept a word.
- `so`  out  1  serial data bit; meaningful only while `so_valid` = 1.
- `so_valid`  out  1  high for exactly 8 consecutive cycles per word.
- `bit_idx`  out  3  index of the bit currently on `so`; counts 0..7 within a word.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- Internal state:
  - FSM with states IDLE, SHIFT, DONE (2-bit encoding).
  - 8-bit shift register `shreg`.
  - 3-bit counter `cnt`.
- Reset (`reset_n` = 0), effective immediately, independent of `clk`:
  - state = IDLE, `shreg` = 0, `cnt` = 0.
  - Outputs: `ready` = 1, `so` = 0, `so_valid` = 0, `bit_idx` = 0, `done` = 0.
- IDLE:
  - `ready` = 1.
  - On `load` = 1 at an edge: `shreg` <= `d`, `cnt` <= 0, go to SHIFT.
  - If `load` = 0, hold; `shreg` is unchanged.
- SHIFT:
  - `so_valid` = 1, `ready` = 0.
  - `so` = `shreg[7]` (MSB_FIRST = 1) or `shreg[0]` (MSB_FIRST = 0).
  - `bit_idx` = `cnt`.
  - Each edge: shift `shreg` toward the output end, filling with 0, and `cnt` <= `cnt` + 1.
  - On the edge where `cnt` == 7: go to DONE. `cnt` wraps to 0.
- DONE:
  - `done` = 1, `so_valid` = 0, `ready` = 0. Next edge: go to IDLE.
- `load` is ignored in SHIFT and DONE. It is not queued, and `d` changes there have no effect.
- All outputs are decoded from registered state (state, `shreg`, `cnt`); no input reaches an output combinationally.
- Shift fill value is 0. After a full word, `shreg` = 8'h00.

## Timing
- Load accepted at edge N:
  - Bits 0..7 of the stream are on `so` during cycles N+1 .. N+8, one per cycle, each stable for a full clock.
  - `done` is high during cycle N+9.
  - `ready` returns high in cycle N+10.
- Throughput: one word per 10 cycles with `load` held high continuously.
- Latency from load edge to first valid bit: 1 cycle. Latency to `done`: 9 cycles.
- `so_valid` is never high in the same cycle as `done` or `ready`.
- Reset asserted mid-word aborts immediately: `so_valid` drops without waiting for an edge and no `done` is produced. After release, the block is in IDLE and accepts a new load on the first edge.
- `bit_idx` wraps 7 -> 0 on the SHIFT -> DONE edge and holds 0 in IDLE and DONE.

## Test plan
- Reset then MSB-first word:
  - Stimulus: hold `reset_n` = 0 for 3 ns and check outputs 0 / `ready` = 1. Release, then load 8'b0010_1100.
  - Required: `so` = 0,0,1,0,1,1,0,0 with `bit_idx` 0..7. `done` pulses once in the 9th cycle after load. `ready` is back in the 10th.
- LSB-first build (MSB_FIRST = 0):
  - Stimulus: load 8'b1000_1111.
  - Required: `so` = 1,1,1,1,0,0,0,1.
- Back-to-back traffic:
  - Stimulus: hold `load` = 1 while presenting 8'b0101_1010, 8'b1011_0111, 8'b1100_1110 in turn.
  - Required: each word is accepted exactly 10 cycles after the previous one. Serial streams are 01011010, 10110111, 11001110.
- Load during busy:
  - Stimulus: pulse `load` with `d` = 8'hFF in bit cycle 4 of word 8'h00.
  - Required: stream stays all zeros, `done` fires on schedule, and 8'hFF is never transmitted.
- Reset mid-word:
  - Stimulus: assert `reset_n` = 0 between edges during bit 3 of 8'hA5.
  - Required: `so_valid`, `so` and `done` are 0 and `ready` = 1 immediately, with no `done` pulse. A subsequent load of 8'h3C streams correctly.
- Idle hold:
  - Stimulus: `load` = 0 for 20 cycles while `d` toggles.
  - Required: `ready` = 1, `so_valid` = 0, `so` = 0 (remains 0 after reset with no load), `done` never asserts.

Source files
------------

// File: rtl/serializer8.sv
// serializer8: byte-wide parallel-in, serial-out transmitter.
// Accepts a word via load/ready, streams 8 bits with valid and index, then pulses done.
module serializer8 #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] d,
    input  logic       load,
    output logic       ready,
    output logic       so,
    output logic       so_valid,
    output logic [2:0] bit_idx,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [7:0] shreg, shreg_nx;
    logic [2:0] cnt, cnt_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            shreg <= 8'h00;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        ready    = 1'b0;
        so_valid = 1'b0;
        done     = 1'b0;
        so       = 1'b0;
        bit_idx  = 3'd0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    shreg_nx = d;
                    cnt_nx   = 3'd0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                so_valid = 1'b1;
                bit_idx  = cnt;
                so       = MSB_FIRST ? shreg[7] : shreg[0];
                // Zero-fill so the register is clear once the word has gone.
                shreg_nx = MSB_FIRST ? {shreg[6:0], 1'b0}
                                     : {1'b0, shreg[7:1]};
                cnt_nx   = cnt + 3'd1;
                if (cnt == 3'd7) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
